addition_kernel_sched: RTL
==========================

// Module: addition_kernel_sched
// PURPOSE
//  Sequencer for the 8-lane addition_kernel. On start, streams a vector of LEN element pairs from two
//  operand buffers through the kernel one LANES-wide chunk at a time and writes sums to a result buffer.
//  Sits between the host/config logic and the kernel; the kernel itself is instantiated alongside, not inside.
// PARAMETERS
//  LANES       8   elements per chunk (kernel lane count)
//  DATA_W      8   element width, bits
//  ADDR_W      8   chunk address width for operand/result buffers
//  LEN_W       11  width of element-count input (ADDR_W + log2(LANES))
//  KERNEL_LAT  1   kernel input-to-output latency, clk cycles (>=1)
// PORTS
//  clk      in   1               single clock, rising edge
//  rst      in   1               asynchronous, active-high reset
//  start    in   1               request a run; sampled only in IDLE
//  len      in   LEN_W           element count; sampled with accepted start
//  busy     out  1               high from cycle after accepted start until DONE inclusive
//  done     out  1               one-cycle pulse at end of run
//  rd_en    out  1               operand buffer read strobe
//  rd_addr  out  ADDR_W          operand chunk address (= chunk index)
//  rd_a     in   LANES*DATA_W    operand A chunk, valid 1 cycle after rd_en; lane i = bits [i*DATA_W +: DATA_W]
//  rd_b     in   LANES*DATA_W    operand B chunk, same timing
//  k_in1    out  LANES*DATA_W    to kernel input1 lanes (registered)
//  k_in2    out  LANES*DATA_W    to kernel input2 lanes (registered)
//  k_out    in   LANES*DATA_W    from kernel output lanes
//  wr_en    out  1               result buffer write strobe
//  wr_addr  out  ADDR_W          result chunk address
//  wr_data  out  LANES*DATA_W    result chunk (k_out pass-through, mod 2^DATA_W wrap, no saturation)
//  wr_mask  out  LANES           per-lane write enable; bit i = lane i valid
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, rd_en, wr_en=0; rd_addr, wr_addr, wr_mask, k_in1, k_in2=0. Reset mid-run aborts at once, no further strobes.
//  nchunks = ceil(len/LANES); last chunk valid lanes = len - (nchunks-1)*LANES.
//  FSM: IDLE -start&len!=0-> FETCH; IDLE -start&len==0-> DONE (no rd_en/wr_en issued).
//   FETCH (1 cyc): rd_en=1, rd_addr=chunk -> LOAD.
//   LOAD (1 cyc): register rd_a/rd_b into k_in1/k_in2; lanes beyond last valid lane forced to 0 -> EXEC.
//   EXEC (KERNEL_LAT cyc, down-counter) -> WRITE.
//   WRITE (1 cyc): wr_en=1, wr_addr=chunk, wr_data=k_out, wr_mask=valid lanes (all 1s except last partial chunk);
//     last chunk -> DONE, else chunk++ -> FETCH.
//   DONE (1 cyc): done=1 -> IDLE.
//  Per chunk: 3+KERNEL_LAT cycles. Start accepted at cycle T: first rd_en at T+1, done at T+1+nchunks*(3+KERNEL_LAT).
//  start while not IDLE ignored (no restart, no len resample); start held high in DONE's following IDLE starts a new run.
//  k_in1/k_in2 hold last loaded values between chunks and after run end; wr_mask/wr_data don't-care when wr_en=0.
//  rd_en, wr_en, done mutually exclusive in any cycle.
//  len > LANES*2^ADDR_W is out of contract (chunk index wraps mod 2^ADDR_W).
// STRUCTURE
//  Shared package addition_kernel_pkg: LANES, DATA_W constants; sched state enum {IDLE,FETCH,LOAD,EXEC,WRITE,DONE};
//  lane slice helper function. Single flat module: FSM + chunk counter + latency counter; no sub-module needed.
//  Bench instantiates addition_kernel + behavioural operand/result buffers.
// TESTING
//  1 len=8, A lanes 0..7, B lanes 8..1, start@0 -> rd_en@1, wr_en@4 wr_mask=8'hFF every lane=8, done@5.
//  2 len=11, chunk1 A=B=1 -> two writes, addr 0 mask 8'hFF, addr 1 mask 8'h07, k_in lanes 3..7 of chunk1=0, done@9.
//  3 len=0 -> done@1, busy@1 only, no rd_en/wr_en ever.
//  4 A lane=200, B lane=100 -> wr_data lane=44 (wrap), no other flag.
//  5 start pulsed again @2 with len=16 during a len=8 run -> ignored, one write, done@5.
//  6 rst asserted @3 mid-run -> all outputs 0 same cycle, no wr_en; fresh start after release runs normally.

Source files
------------

// File: rtl/addition_kernel_pkg.sv
// Shared constants, scheduler state encoding and lane helpers for the addition kernel and its sequencer.
package addition_kernel_pkg;

    localparam int LANES  = 8;
    localparam int DATA_W = 8;
    localparam int VEC_W  = LANES * DATA_W;
    localparam int LSB_W  = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EXEC,
        WRITE,
        DONE
    } sched_state_t;

    function automatic logic [DATA_W-1:0] lane_slice(input logic [VEC_W-1:0] vec, input int unsigned idx);
        return vec[idx*DATA_W +: DATA_W];
    endfunction

    // Mask with lanes 0..top set; top is the index of the highest valid lane.
    function automatic logic [LANES-1:0] lane_mask(input logic [LSB_W-1:0] top);
        logic [LANES-1:0] all_ones;
        all_ones = '1;
        return all_ones >> (LANES - 1 - int'(top));
    endfunction

endpackage

// File: rtl/addition_kernel.sv
// Purpose: lane-parallel modular adder, one registered stage.
// Latency: 1 clk from in1/in2 to sum.
// Backpressure: none; accepts a new vector every cycle.
module addition_kernel
    import addition_kernel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [VEC_W-1:0] in1,
    input  logic [VEC_W-1:0] in2,
    output logic [VEC_W-1:0] sum
);

    logic [VEC_W-1:0] sum_comb;

    always_comb begin
        sum_comb = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_comb[i*DATA_W +: DATA_W] = lane_slice(in1, i) + lane_slice(in2, i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else begin
            sum <= sum_comb;
        end
    end

endmodule

// File: rtl/addition_kernel_sched.sv
// Purpose: walks LEN elements through the addition kernel one LANES-wide chunk at a time.
// Latency: 3+KERNEL_LAT clk per chunk; done at T+1+nchunks*(3+KERNEL_LAT) after start at T.
// Backpressure: none; start is ignored while a run is in progress.
module addition_kernel_sched
    import addition_kernel_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = ADDR_W + $clog2(addition_kernel_pkg::LANES),
    parameter int KERNEL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [VEC_W-1:0]   rd_a,
    input  logic [VEC_W-1:0]   rd_b,
    output logic [VEC_W-1:0]   k_in1,
    output logic [VEC_W-1:0]   k_in2,
    input  logic [VEC_W-1:0]   k_out,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [VEC_W-1:0]   wr_data,
    output logic [LANES-1:0]   wr_mask
);

    localparam int CNT_W = (KERNEL_LAT > 1) ? $clog2(KERNEL_LAT) : 1;

    sched_state_t      state, state_nxt;
    logic [ADDR_W-1:0] chunk;
    logic [ADDR_W-1:0] last_chunk;
    logic [LANES-1:0]  last_mask;
    logic [CNT_W-1:0]  lat_cnt;
    logic [LEN_W-1:0]  len_m1;
    logic              is_last;
    logic [LANES-1:0]  cur_mask;
    logic [VEC_W-1:0]  lane_en;

    assign len_m1   = len - LEN_W'(1);
    assign is_last  = (chunk == last_chunk);
    assign cur_mask = is_last ? last_mask : '1;

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_en[i*DATA_W +: DATA_W] = {DATA_W{cur_mask[i]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        rd_addr   = chunk;
        wr_addr   = chunk;
        wr_data   = k_out;
        wr_mask   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                if (lat_cnt == '0) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                wr_mask   = cur_mask;
                state_nxt = is_last ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk      <= '0;
            last_chunk <= '0;
            last_mask  <= '0;
            lat_cnt    <= '0;
            k_in1      <= '0;
            k_in2      <= '0;
        end else begin
            if (state == IDLE && start && len != '0) begin
                chunk      <= '0;
                last_chunk <= ADDR_W'(len_m1 >> LSB_W);
                last_mask  <= lane_mask(len_m1[LSB_W-1:0]);
            end
            // Lanes past the end of the vector are zeroed so the kernel never sees stale data.
            if (state == LOAD) begin
                k_in1 <= rd_a & lane_en;
                k_in2 <= rd_b & lane_en;
            end
            if (state == FETCH) begin
                lat_cnt <= CNT_W'(KERNEL_LAT - 1);
            end else if (state == EXEC && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
            end
            if (state == WRITE && !is_last) begin
                chunk <= chunk + ADDR_W'(1);
            end
        end
    end

endmodule
